// File: rtl/mul8_rr_sched_pkg.sv
// Shared types for mul8_rr_sched: FSM encoding and the per-step nibble/shift schedule.
// The step table maps each Pn state onto the 4x4 core operands and the weight of its product.
package mul8_rr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Nibble selects: 1 picks [7:4], 0 picks [3:0]
  localparam logic SEL_A_P0 = 1'b0;
  localparam logic SEL_A_P1 = 1'b1;
  localparam logic SEL_A_P2 = 1'b0;
  localparam logic SEL_A_P3 = 1'b1;
  localparam logic SEL_B_P0 = 1'b0;
  localparam logic SEL_B_P1 = 1'b0;
  localparam logic SEL_B_P2 = 1'b1;
  localparam logic SEL_B_P3 = 1'b1;

  localparam logic [3:0] SHIFT_P0 = 4'd0;
  localparam logic [3:0] SHIFT_P1 = 4'd4;
  localparam logic [3:0] SHIFT_P2 = 4'd4;
  localparam logic [3:0] SHIFT_P3 = 4'd8;

  typedef struct packed {
    logic       a_hi;
    logic       b_hi;
    logic [3:0] shift;
  } step_t;

  function automatic step_t step_of(state_t s);
    step_t st;
    st = '{a_hi: SEL_A_P0, b_hi: SEL_B_P0, shift: SHIFT_P0};
    case (s)
      ST_P1:   st = '{a_hi: SEL_A_P1, b_hi: SEL_B_P1, shift: SHIFT_P1};
      ST_P2:   st = '{a_hi: SEL_A_P2, b_hi: SEL_B_P2, shift: SHIFT_P2};
      ST_P3:   st = '{a_hi: SEL_A_P3, b_hi: SEL_B_P3, shift: SHIFT_P3};
      default: st = '{a_hi: SEL_A_P0, b_hi: SEL_B_P0, shift: SHIFT_P0};
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mul4x4_core.sv
// 4x4 unsigned combinational multiplier core; zero latency.
// No flow control: purely combinational, product split as {carry, 7-bit sum}.
module mul4x4_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       carry,
  output logic [6:0] sum
);

  logic [7:0] prod;

  assign prod         = {4'b0000, a} * {4'b0000, b};
  assign {carry, sum} = prod;

endmodule

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter; grant is combinational from requests, last_grant updates on a grant.
// No backpressure of its own: the caller gates requests so a grant always means acceptance.
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;

  // On contention the requester that did not win last time goes first
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = last_grant;
      gnt1 = ~last_grant;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ~RR_INIT;
    end else if (gnt0 || gnt1) begin
      last_grant <= gnt1;
    end
  end

endmodule

// File: rtl/mul8_rr_sched.sv
// Two-requester 8x8 multiply scheduler over one shared 4x4 core; result after 4 edges from accept.
// Requests are readied only in IDLE; res_ready low parks the FSM in DONE with the result held.
module mul8_rr_sched
  import mul8_rr_sched_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in0_valid,
  input  logic [7:0]  in0_a,
  input  logic [7:0]  in0_b,
  output logic        in0_ready,
  input  logic        in1_valid,
  input  logic [7:0]  in1_a,
  input  logic [7:0]  in1_b,
  output logic        in1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_p,
  output logic        res_id,
  output logic        busy
);

  state_t      state;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] acc;
  logic        id_q;

  logic        idle;
  logic        gnt0;
  logic        gnt1;
  logic        accept;

  step_t       step;
  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic        core_carry;
  logic [6:0]  core_sum;
  logic [15:0] pp_ext;
  logic [15:0] acc_sum;

  assign idle = (state == ST_IDLE);

  rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (in0_valid && idle),
    .req1  (in1_valid && idle),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign in0_ready = gnt0;
  assign in1_ready = gnt1;
  assign accept    = gnt0 || gnt1;

  assign step   = step_of(state);
  assign core_a = step.a_hi ? op_a[7:4] : op_a[3:0];
  assign core_b = step.b_hi ? op_b[7:4] : op_b[3:0];

  mul4x4_core u_core (
    .a     (core_a),
    .b     (core_b),
    .carry (core_carry),
    .sum   (core_sum)
  );

  // Largest partial sum is 0xFE01, so the 16-bit accumulator never wraps
  assign pp_ext  = {8'h00, core_carry, core_sum};
  assign acc_sum = acc + (pp_ext << step.shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_a      <= 8'h00;
      op_b      <= 8'h00;
      acc       <= 16'h0000;
      id_q      <= 1'b0;
      res_valid <= 1'b0;
      res_p     <= 16'h0000;
      res_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a  <= gnt1 ? in1_a : in0_a;
            op_b  <= gnt1 ? in1_b : in0_b;
            id_q  <= gnt1;
            acc   <= 16'h0000;
            busy  <= 1'b1;
            state <= ST_P0;
          end
        end
        ST_P0: begin
          acc   <= acc_sum;
          state <= ST_P1;
        end
        ST_P1: begin
          acc   <= acc_sum;
          state <= ST_P2;
        end
        ST_P2: begin
          acc   <= acc_sum;
          state <= ST_P3;
        end
        ST_P3: begin
          acc       <= acc_sum;
          res_p     <= acc_sum;
          res_id    <= id_q;
          res_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul8_rr_sched.md
Name: mul8_rr_sched

Overview:
- Shared-resource scheduler and sequencer around one 4x4 unsigned combinational multiplier core.
- Two requesters submit 8x8 unsigned multiply jobs over valid/ready.
- A round-robin arbiter grants one job at a time. An FSM drives the single core over four nibble-product cycles and accumulates the 16-bit result.
- The result returns tagged with the requester index.
- Sits between requesting datapath blocks and the reduced-area multiplier, trading throughput for area.

Parameters:
- RR_INIT, 0, requester given priority after reset when both request in the same cycle (0 or 1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in0_valid  input  1  requester 0 job valid
- in0_a  input  8  requester 0 multiplicand
- in0_b  input  8  requester 0 multiplier
- in0_ready  output  1  requester 0 job accepted this cycle when high with in0_valid
- in1_valid  input  1  requester 1 job valid
- in1_a  input  8  requester 1 multiplicand
- in1_b  input  8  requester 1 multiplier
- in1_ready  output  1  requester 1 job accepted this cycle when high with in1_valid
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- res_p  output  16  unsigned product a*b
- res_id  output  1  index of requester that issued the job
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - res_valid=0, res_p=0, res_id=0, busy=0, in0_ready=0, in1_ready=0.
  - FSM=IDLE, accumulator=0, operand regs=0, last_grant=~RR_INIT.
- FSM states: IDLE, P0, P1, P2, P3, DONE.
- IDLE:
  - in0_ready / in1_ready are combinational from valids, asserted only in IDLE.
  - Only one valid high: that requester is readied.
  - Both valid high: ready goes to the requester != last_grant.
  - Never both readies high in the same cycle.
  - On an accepting edge: latch A and B, latch id, set last_grant=id, clear the accumulator, go to P0.
- Core operand mux and accumulation (acc is 16-bit; pp = 8-bit core product, {carry, 7-bit sum}):
  - P0: core(A[3:0], B[3:0]); acc += pp.
  - P1: core(A[7:4], B[3:0]); acc += pp<<4.
  - P2: core(A[3:0], B[7:4]); acc += pp<<4.
  - P3: core(A[7:4], B[7:4]); acc += pp<<8. Then go to DONE.
- Width rule: the 16-bit acc cannot overflow (max 0xFE01). Additions are unsigned and zero-extended.
- DONE:
  - res_valid=1; res_p=acc and res_id are held stable until res_ready.
  - On res_valid&res_ready: res_valid drops and the FSM goes to IDLE.
  - No input is accepted in DONE or in the Pn states.
- Latency: with the accepting edge as edge 0, res_valid is high after edge 4. Minimum issue interval is 6 cycles (DONE with res_ready=1, then IDLE).
- Backpressure: res_ready low holds DONE indefinitely; both in*_ready stay 0.
- Requester withdrawal: in*_valid dropping while not ready has no effect. A request is only committed on valid&ready.
- Reset mid-operation: the job is discarded silently with no partial result. All outputs return to reset values immediately (asynchronously).
- res_p is registered; no combinational path from inputs to res_*.

Decomposition:
- Shared package/include:
  - State encoding constants (IDLE..DONE, 3-bit).
  - Nibble-select constants per state.
  - Shift amounts 0/4/4/8.
- Sub-modules:
  - The existing 4x4 core instanced unchanged; its {carry, sum} concatenation forms pp.
  - One natural sub-module: rr_arb2 (2-way round-robin grant with last_grant register).
- Parent holds the FSM, operand regs, accumulator and output regs.

Test Plan:
- Basic product: reset, in0 a=0x12, b=0x34 -> res_valid after edge 4, res_p=0x03A8, res_id=0; busy high in P0..DONE.
- Maximum value: in1 a=0xFF, b=0xFF -> res_p=0xFE01, res_id=1; zero operand a=0x00, b=0xA5 -> res_p=0x0000.
- Simultaneous requests, RR_INIT=0:
  - in0 (0x03*0x05) and in1 (0x10*0x10) both valid.
  - Expect results 0x000F id 0, then 0x0100 id 1.
  - Repeat with both valid again -> order alternates; in0_ready and in1_ready never both high.
- Backpressure: hold res_ready=0 for 3 cycles in DONE -> res_p/res_id stable, res_valid=1, in0_ready=in1_ready=0; the job starts on the cycle after the handshake.
- Reset mid-operation: assert rst_n=0 during P2 -> all outputs immediately 0, no result emitted. Next job 0x0B*0x0D -> 0x008F.
